ctmm_load: RTL and testbench

Implements the CLOOMC LOAD Church-instruction, `LOAD CRd, CRs[Index]`, the read-side counterpart of SAVE. It reads the capability in C-List register CRs (CR0-CR6) and checks that it grants L permission and that Index is in bounds. It then fetches the 64-bit Golden Token at that C-List slot from memory and writes it into CRd. The block sits beside SAVE in the CTMM instruction unit and shares the capability register file read port and the memory system.

---
 rtl/ctmm_pkg.sv | 20 ++
 rtl/ctmm_load_if.sv | 34 +++
 rtl/ctmm_load.sv | 125 ++++++++++++
 tb/tb_ctmm_load.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ctmm_pkg.sv
// rtl/ctmm_pkg.sv - shared CTMM capability and fault types
package ctmm_pkg;

    // Golden Token permission bit that grants LOAD through a C-List
    localparam int unsigned GT_PERM_L = 1;

    typedef enum logic [3:0] {
        FAULT_NONE   = 4'd0,
        FAULT_PERM   = 4'd1,
        FAULT_BOUNDS = 4'd2
    } fault_type_t;

    typedef struct packed {
        logic [63:0] word0_gt;
        logic [63:0] word1_base;
        logic [63:0] word2_limit;
        logic [63:0] word3_seals;
    } capability_reg_t;

endpackage

// File: rtl/ctmm_load_if.sv
// rtl/ctmm_load_if.sv - LOAD command, register file and memory port bundle
interface ctmm_load_if;
    import ctmm_pkg::*;

    logic            load_start;
    logic [3:0]      cr_src;
    logic [3:0]      cr_dst;
    logic [7:0]      index;
    logic            load_busy;
    logic            load_complete;
    logic            load_fault;
    fault_type_t     fault_type;
    logic [3:0]      cr_rd_addr;
    capability_reg_t cr_rd_data;
    logic [3:0]      cr_wr_addr;
    capability_reg_t cr_wr_data;
    logic            cr_wr_en;
    logic [63:0]     mem_rd_addr;
    logic            mem_rd_en;
    logic [63:0]     mem_rd_data;
    logic            mem_rd_valid;

    modport master (
        output load_start, cr_src, cr_dst, index, cr_rd_data, mem_rd_data, mem_rd_valid,
        input  load_busy, load_complete, load_fault, fault_type, cr_rd_addr,
               cr_wr_addr, cr_wr_data, cr_wr_en, mem_rd_addr, mem_rd_en
    );

    modport slave (
        input  load_start, cr_src, cr_dst, index, cr_rd_data, mem_rd_data, mem_rd_valid,
        output load_busy, load_complete, load_fault, fault_type, cr_rd_addr,
               cr_wr_addr, cr_wr_data, cr_wr_en, mem_rd_addr, mem_rd_en
    );
endinterface

// File: rtl/ctmm_load.sv
// rtl/ctmm_load.sv - LOAD CRd, CRs[Index]: checked Golden Token fetch into a capability register
module ctmm_load (
    input  logic       clk,
    input  logic       rst_n,
    ctmm_load_if.slave bus
);
    import ctmm_pkg::*;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        CHECK_READ = 3'd1,
        LATCH_SRC  = 3'd2,
        CHECK_PERM = 3'd3,
        MEM_WAIT   = 3'd4,
        WRITE_CR   = 3'd5
    } state_t;

    state_t      state;
    logic [3:0]  src_q;
    logic [3:0]  dst_q;
    logic [7:0]  index_q;
    logic        src_perm_l;
    logic [63:0] src_base;
    logic [31:0] src_limit;
    logic [64:0] addr_sum;

    // 65-bit so a slot address wrapping past the top of memory shows up as a carry
    assign addr_sum  = {1'b0, src_base} + {1'b0, 53'b0, index_q, 3'b0};
    assign bus.load_busy = (state != IDLE);

    // Read address goes out in the start cycle so data is ready for LATCH_SRC
    always_comb begin
        bus.cr_rd_addr = 4'd0;
        if (state == IDLE && bus.load_start) begin
            bus.cr_rd_addr = bus.cr_src;
        end else if (state == CHECK_READ) begin
            bus.cr_rd_addr = src_q;
        end
    end

    // Control FSM with registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state             <= IDLE;
            src_q             <= 4'd0;
            dst_q             <= 4'd0;
            index_q           <= 8'd0;
            src_perm_l        <= 1'b0;
            src_base          <= 64'd0;
            src_limit         <= 32'd0;
            bus.load_complete <= 1'b0;
            bus.load_fault    <= 1'b0;
            bus.fault_type    <= FAULT_NONE;
            bus.cr_wr_addr    <= 4'd0;
            bus.cr_wr_data    <= '0;
            bus.cr_wr_en      <= 1'b0;
            bus.mem_rd_addr   <= 64'd0;
            bus.mem_rd_en     <= 1'b0;
        end else begin
            bus.load_complete <= 1'b0;
            bus.cr_wr_en      <= 1'b0;
            bus.cr_wr_addr    <= 4'd0;
            bus.cr_wr_data    <= '0;
            case (state)
                IDLE: begin
                    if (bus.load_start) begin
                        src_q          <= bus.cr_src;
                        dst_q          <= bus.cr_dst;
                        index_q        <= bus.index;
                        bus.load_fault <= 1'b0;
                        bus.fault_type <= FAULT_NONE;
                        state          <= CHECK_READ;
                    end
                end
                CHECK_READ: begin
                    if (src_q > 4'd6) begin
                        bus.load_fault <= 1'b1;
                        bus.fault_type <= FAULT_PERM;
                        state          <= IDLE;
                    end else begin
                        state <= LATCH_SRC;
                    end
                end
                LATCH_SRC: begin
                    src_perm_l <= bus.cr_rd_data.word0_gt[GT_PERM_L];
                    src_base   <= bus.cr_rd_data.word1_base;
                    src_limit  <= bus.cr_rd_data.word2_limit[31:0];
                    state      <= CHECK_PERM;
                end
                CHECK_PERM: begin
                    if (!src_perm_l) begin
                        bus.load_fault <= 1'b1;
                        bus.fault_type <= FAULT_PERM;
                        state          <= IDLE;
                    end else if ({24'b0, index_q} >= src_limit || addr_sum[64]) begin
                        bus.load_fault <= 1'b1;
                        bus.fault_type <= FAULT_BOUNDS;
                        state          <= IDLE;
                    end else begin
                        bus.mem_rd_en   <= 1'b1;
                        bus.mem_rd_addr <= addr_sum[63:0];
                        state           <= MEM_WAIT;
                    end
                end
                MEM_WAIT: begin
                    if (bus.mem_rd_valid) begin
                        bus.mem_rd_en           <= 1'b0;
                        bus.mem_rd_addr         <= 64'd0;
                        bus.cr_wr_en            <= 1'b1;
                        bus.cr_wr_addr          <= dst_q;
                        bus.cr_wr_data.word0_gt <= bus.mem_rd_data;
                        bus.load_complete       <= 1'b1;
                        state                   <= WRITE_CR;
                    end
                end
                WRITE_CR: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ctmm_load.sv
// tb/tb_ctmm_load.sv - directed self-checking bench for ctmm_load
module tb_ctmm_load;
    import ctmm_pkg::*;

    localparam int INF = 1 << 30;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ctmm_load_if bus ();
    ctmm_load dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // capability register file contents set by the stimulus; one-cycle read latency
    capability_reg_t cap [16];
    always @(posedge clk) bus.cr_rd_data <= cap[bus.cr_rd_addr];

    // write / completion / fault-edge log
    int              wr_cnt = 0;
    int              cmp_cnt = 0;
    int              wr_cyc = 0;
    int              rise_cyc = 0;
    logic [3:0]      wr_addr_log = '0;
    capability_reg_t wr_data_log = '0;
    logic            fault_prev = 1'b0;
    always @(posedge clk) begin
        if (bus.cr_wr_en) begin
            wr_cnt      <= wr_cnt + 1;
            wr_cyc      <= cyc;
            wr_addr_log <= bus.cr_wr_addr;
            wr_data_log <= bus.cr_wr_data;
        end
        if (bus.load_complete) cmp_cnt <= cmp_cnt + 1;
        fault_prev <= bus.load_fault;
        if (bus.load_fault && !fault_prev) rise_cyc <= cyc;
    end

    // model of the operation in flight: s = cycle of the accepting edge's period (cycle 0)
    int          s = 0;
    int          e = INF;
    int          kind = 0;   // 0 none, 1 CRs range fault, 2 perm/bounds fault, 3 fetch
    logic [3:0]  m_src = '0;
    logic [3:0]  m_dst = '0;
    logic [63:0] m_addr = '0;
    logic [63:0] m_gt = '0;
    int          pf_cyc = INF;
    fault_type_t pf_type = FAULT_NONE;
    bit          m_rst = 1'b1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // what LOAD must do with a given source register and index
    function automatic void predict(input logic [3:0] src, input logic [7:0] idx,
                                    output int k, output fault_type_t ft, output logic [63:0] a);
        capability_reg_t c;
        logic [64:0]     sum;
        a  = '0;
        ft = FAULT_NONE;
        k  = 3;
        if (src > 4'd6) begin
            k  = 1;
            ft = FAULT_PERM;
        end else begin
            c   = cap[src];
            sum = 65'(c.word1_base) + 65'(idx) * 65'd8;
            if (!c.word0_gt[GT_PERM_L]) begin
                k = 2; ft = FAULT_PERM;
            end else if (32'(idx) >= c.word2_limit[31:0]) begin
                k = 2; ft = FAULT_BOUNDS;
            end else if (sum[64]) begin
                k = 2; ft = FAULT_BOUNDS;
            end else begin
                a = sum[63:0];
            end
        end
    endfunction

    // per-cycle comparison of every output against the model
    always @(negedge clk) begin
        logic        e_busy, e_mem, e_wr, e_fault;
        logic [3:0]  e_rd;
        fault_type_t e_ft;
        e_busy = 1'b0;
        if (!m_rst) begin
            case (kind)
                1: e_busy = (cyc == s + 1);
                2: e_busy = (cyc >= s + 1 && cyc <= s + 3);
                3: e_busy = (cyc >= s + 1 && cyc <= e);
                default: e_busy = 1'b0;
            endcase
        end
        e_mem   = !m_rst && kind == 3 && cyc >= s + 4 && cyc < e;
        e_wr    = !m_rst && kind == 3 && cyc == e;
        e_fault = !m_rst && cyc >= pf_cyc;
        e_ft    = e_fault ? pf_type : FAULT_NONE;
        if (m_rst) e_rd = 4'd0;
        else if (bus.load_start && !e_busy) e_rd = bus.cr_src;
        else if (kind != 0 && cyc == s + 1) e_rd = m_src;
        else e_rd = 4'd0;
        chk("load_busy", 64'(bus.load_busy), 64'(e_busy));
        chk("load_complete", 64'(bus.load_complete), 64'(e_wr));
        chk("load_fault", 64'(bus.load_fault), 64'(e_fault));
        chk("fault_type", 64'(bus.fault_type), 64'(e_ft));
        chk("cr_rd_addr", 64'(bus.cr_rd_addr), 64'(e_rd));
        chk("mem_rd_en", 64'(bus.mem_rd_en), 64'(e_mem));
        chk("mem_rd_addr", bus.mem_rd_addr, e_mem ? m_addr : 64'd0);
        chk("cr_wr_en", 64'(bus.cr_wr_en), 64'(e_wr));
        chk("cr_wr_addr", 64'(bus.cr_wr_addr), e_wr ? 64'(m_dst) : 64'd0);
        chk("cr_wr_word0", bus.cr_wr_data.word0_gt, e_wr ? m_gt : 64'd0);
        chk("cr_wr_rest", 64'(|{bus.cr_wr_data.word1_base, bus.cr_wr_data.word2_limit,
                               bus.cr_wr_data.word3_seals}), 64'd0);
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    // one-cycle start pulse; returns 1ns after the accepting edge
    task automatic start_op(input logic [3:0] src, input logic [3:0] dst, input logic [7:0] idx);
        int          k;
        fault_type_t ft;
        logic [63:0] a;
        @(posedge clk);
        #2;
        bus.load_start = 1'b1;
        bus.cr_src     = src;
        bus.cr_dst     = dst;
        bus.index      = idx;
        @(posedge clk);
        #1;
        bus.load_start = 1'b0;
        predict(src, idx, k, ft, a);
        s       = cyc - 1;
        kind    = k;
        e       = INF;
        m_src   = src;
        m_dst   = dst;
        m_addr  = a;
        pf_type = ft;
        pf_cyc  = (k == 1) ? s + 2 : (k == 2) ? s + 4 : INF;
    endtask

    // memory answers d cycles after the first MEM_WAIT cycle
    task automatic respond(input int d, input logic [63:0] gt);
        while (cyc != s + 4 + d) begin
            @(posedge clk);
            #2;
        end
        bus.mem_rd_data  = gt;
        bus.mem_rd_valid = 1'b1;
        m_gt = gt;
        e    = cyc + 1;
        @(posedge clk);
        #1;
        bus.mem_rd_valid = 1'b0;
        bus.mem_rd_data  = '0;
        @(posedge clk);
        #2;
    endtask

    function automatic capability_reg_t mk_cap(input bit l, input logic [63:0] base,
                                               input logic [31:0] limit);
        capability_reg_t c;
        c = '0;
        c.word0_gt[GT_PERM_L] = l;
        c.word1_base  = base;
        c.word2_limit = 64'(limit);
        return c;
    endfunction

    initial begin
        int wc0, cc0;
        bus.load_start   = 1'b0;
        bus.cr_src       = '0;
        bus.cr_dst       = '0;
        bus.index        = '0;
        bus.mem_rd_data  = '0;
        bus.mem_rd_valid = 1'b0;
        for (int i = 0; i < 16; i++) cap[i] = '0;
        cap[2] = mk_cap(1'b1, 64'h1000, 32'd16);
        cap[3] = mk_cap(1'b0, 64'h2000, 32'd16);
        cap[4] = mk_cap(1'b1, 64'hFFFF_FFFF_FFFF_FFF8, 32'd16);

        @(posedge clk);
        #2;
        chk("reset_fault_type", 64'(bus.fault_type), 64'(FAULT_NONE));
        chk("reset_busy", 64'(bus.load_busy), 64'd0);
        wait_cyc(2);
        rst_n = 1'b1;
        m_rst = 1'b0;
        wait_cyc(2);

        // LOAD CR9, CR2[5] with one-cycle memory latency
        wc0 = wr_cnt; cc0 = cmp_cnt;
        start_op(4'd2, 4'd9, 8'd5);
        chk("t1_model_addr", m_addr, 64'h1028);
        respond(1, 64'hDEAD_BEEF_0000_0042);
        chk("t1_wr_cycle", 64'(wr_cyc - s), 64'd6);
        chk("t1_wr_addr", 64'(wr_addr_log), 64'd9);
        chk("t1_wr_gt", wr_data_log.word0_gt, 64'hDEAD_BEEF_0000_0042);
        chk("t1_wr_count", 64'(wr_cnt - wc0), 64'd1);
        chk("t1_complete_count", 64'(cmp_cnt - cc0), 64'd1);
        chk("t1_no_fault", 64'(bus.load_fault), 64'd0);

        // CRs out of range
        wc0 = wr_cnt;
        start_op(4'd7, 4'd1, 8'd0);
        wait_cyc(4);
        chk("t2_fault", 64'(bus.load_fault), 64'd1);
        chk("t2_type", 64'(bus.fault_type), 64'(FAULT_PERM));
        chk("t2_rise_cycle", 64'(rise_cyc - s), 64'd2);
        chk("t2_no_write", 64'(wr_cnt - wc0), 64'd0);

        // L permission clear
        start_op(4'd3, 4'd4, 8'd1);
        wait_cyc(5);
        chk("t3_type", 64'(bus.fault_type), 64'(FAULT_PERM));
        chk("t3_rise_cycle", 64'(rise_cyc - s), 64'd4);

        // index == limit
        start_op(4'd2, 4'd4, 8'd16);
        wait_cyc(5);
        chk("t4_type", 64'(bus.fault_type), 64'(FAULT_BOUNDS));

        // last legal slot, minimum latency, also clears the held fault
        start_op(4'd2, 4'd4, 8'd15);
        chk("t5_model_addr", m_addr, 64'h1078);
        respond(0, 64'h0123_4567_89AB_CDEF);
        chk("t5_wr_cycle", 64'(wr_cyc - s), 64'd5);
        chk("t5_fault_cleared", 64'(bus.load_fault), 64'd0);

        // base + index*8 carries out of 64 bits
        start_op(4'd4, 4'd5, 8'd1);
        wait_cyc(5);
        chk("t6_type", 64'(bus.fault_type), 64'(FAULT_BOUNDS));
        // same base at index 0 is the top slot and is legal
        start_op(4'd4, 4'd5, 8'd0);
        chk("t6_model_addr", m_addr, 64'hFFFF_FFFF_FFFF_FFF8);
        respond(2, 64'h5555_AAAA_5555_AAAA);

        // CRd = CRs
        start_op(4'd2, 4'd2, 8'd0);
        respond(0, 64'h0000_0000_0000_0001);
        chk("t7_wr_addr", 64'(wr_addr_log), 64'd2);

        // 20-cycle memory wait with an ignored second start
        wc0 = wr_cnt;
        start_op(4'd2, 4'd10, 8'd3);
        while (cyc != s + 10) begin
            @(posedge clk);
            #2;
        end
        bus.load_start = 1'b1;
        bus.cr_src     = 4'd6;
        bus.cr_dst     = 4'd1;
        bus.index      = 8'd0;
        @(posedge clk);
        #1;
        bus.load_start = 1'b0;
        respond(20, 64'hCAFE_F00D_1234_5678);
        chk("t8_wr_addr", 64'(wr_addr_log), 64'd10);
        chk("t8_wr_count", 64'(wr_cnt - wc0), 64'd1);
        chk("t8_latency", 64'(wr_cyc - s), 64'd25);

        // reset during MEM_WAIT, then a stale memory response
        wc0 = wr_cnt;
        start_op(4'd2, 4'd11, 8'd2);
        while (cyc != s + 6) begin
            @(posedge clk);
            #2;
        end
        rst_n  = 1'b0;
        m_rst  = 1'b1;
        kind   = 0;
        pf_cyc = INF;
        #1;
        chk("t9_async_mem_en", 64'(bus.mem_rd_en), 64'd0);
        chk("t9_async_busy", 64'(bus.load_busy), 64'd0);
        wait_cyc(2);
        rst_n = 1'b1;
        m_rst = 1'b0;
        wait_cyc(1);
        bus.mem_rd_data  = 64'hBAD0_BAD0_BAD0_BAD0;
        bus.mem_rd_valid = 1'b1;
        wait_cyc(1);
        bus.mem_rd_valid = 1'b0;
        bus.mem_rd_data  = '0;
        wait_cyc(4);
        chk("t9_no_write", 64'(wr_cnt - wc0), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
